// File: rtl/usb_sync_rx_ctrl.sv
// USB receive-side SYNC hunt / packet body tracking controller.
// Optional cumulative sync-error counter is enabled by defining USB_SYNC_RX_CTRL_ERRCNT_EN.
module usb_sync_rx_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 3,
  parameter int MAX_BITS       = 1024,
  parameter int CW             = $clog2(MAX_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          k,
  input  logic          j,
  input  logic          se0,
  input  logic          synced_d,
  input  logic          sync_err_d,
  output logic          rx_en,
  output logic          det_rst,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic [CW-1:0] bit_cnt,
  output logic [7:0]    sync_err_total
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [CW-1:0] BITS_MAX   = CW'(MAX_BITS);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_RETRY   = 2'b10;
  localparam logic [1:0] ST_BABBLE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        r_state,   w_state_nxt;
  logic [TW-1:0] r_timer,   w_timer_nxt;
  logic [RW-1:0] r_retry,   w_retry_nxt;
  logic [CW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [1:0]    r_status,  w_status_nxt;
  logic          r_se0_run, w_se0_run_nxt;
  logic          w_kj_bit;
  logic          w_se0_only;
  logic          w_retry_out;

  assign w_kj_bit    = k ^ j;
  assign w_se0_only  = se0 & ~k & ~j;
  assign w_retry_out = sync_err_d && ((r_retry + RW'(1)) == RETRY_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_retry   <= '0;
      r_bit_cnt <= '0;
      r_status  <= ST_OK;
      r_se0_run <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_retry   <= w_retry_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_status  <= w_status_nxt;
      r_se0_run <= w_se0_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_retry_nxt   = r_retry;
    w_bit_cnt_nxt = r_bit_cnt;
    w_status_nxt  = r_status;
    w_se0_run_nxt = r_se0_run;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_timer_nxt   = '0;
          w_retry_nxt   = '0;
          w_bit_cnt_nxt = '0;
          w_status_nxt  = ST_OK;
          w_se0_run_nxt = 1'b0;
          w_state_nxt   = HUNT;
        end
      end

      HUNT: begin
        if (r_timer != TIMER_LAST) begin
          w_timer_nxt = r_timer + TW'(1);
        end
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (synced_d) begin
          w_se0_run_nxt = 1'b0;
          w_state_nxt   = RECV;
        end else begin
          // A non-exhausting sync error still lets the total window expire this cycle.
          if (sync_err_d) begin
            w_retry_nxt = r_retry + RW'(1);
          end
          if (w_retry_out) begin
            w_status_nxt = ST_RETRY;
            w_state_nxt  = DONE;
          end else if (r_timer == TIMER_LAST) begin
            w_status_nxt = ST_TIMEOUT;
            w_state_nxt  = DONE;
          end
        end
      end

      RECV: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_kj_bit) begin
          w_se0_run_nxt = 1'b0;
          if (r_bit_cnt == BITS_MAX) begin
            w_status_nxt = ST_BABBLE;
            w_state_nxt  = DONE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
          end
        end else if (w_se0_only) begin
          if (r_se0_run) begin
            w_status_nxt = ST_OK;
            w_state_nxt  = DONE;
          end else begin
            w_se0_run_nxt = 1'b1;
          end
        end else begin
          w_se0_run_nxt = 1'b0;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign rx_en   = (r_state == HUNT);
  assign det_rst = (r_state != HUNT);
  assign busy    = (r_state == HUNT) || (r_state == RECV);
  assign done    = (r_state == DONE);
  assign status  = r_status;
  assign bit_cnt = r_bit_cnt;

`ifdef USB_SYNC_RX_CTRL_ERRCNT_EN
  logic [7:0] r_err_total;
  logic       w_err_acc;

  // Only errors that win the HUNT priority (no abort, no simultaneous sync) are counted.
  assign w_err_acc = (r_state == HUNT) && !abort && !synced_d && sync_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_total <= '0;
    end else if (w_err_acc && (r_err_total != 8'hFF)) begin
      r_err_total <= r_err_total + 8'd1;
    end
  end

  assign sync_err_total = r_err_total;
`else
  assign sync_err_total = '0;
`endif

endmodule

// File: tb/tb_usb_sync_rx_ctrl.sv
// Scoreboard bench for usb_sync_rx_ctrl: directed scenarios push expected done
// records (cycle, status, bit_cnt); a negedge monitor pops and compares them.
module tb_usb_sync_rx_ctrl;

  localparam int T  = 8;
  localparam int R  = 3;
  localparam int MB = 16;
  localparam int CW = $clog2(MB + 1);

`ifdef USB_SYNC_RX_CTRL_ERRCNT_EN
  localparam int ERRCNT = 1;
`else
  localparam int ERRCNT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, abort, k, j, se0, synced_d, sync_err_d;
  logic          rx_en, det_rst, busy, done;
  logic [1:0]    status;
  logic [CW-1:0] bit_cnt;
  logic [7:0]    sync_err_total;

  usb_sync_rx_ctrl #(
    .TIMEOUT_CYCLES(T),
    .MAX_RETRY     (R),
    .MAX_BITS      (MB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .k             (k),
    .j             (j),
    .se0           (se0),
    .synced_d      (synced_d),
    .sync_err_d    (sync_err_d),
    .rx_en         (rx_en),
    .det_rst       (det_rst),
    .busy          (busy),
    .done          (done),
    .status        (status),
    .bit_cnt       (bit_cnt),
    .sync_err_total(sync_err_total)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int at;
    int st;
    int bc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_done(input int at, input int st, input int bc);
    exp_t e;
    e.at = at;
    e.st = st;
    e.bc = bc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("done_status", 32'(status), e.st);
        chk("done_bit_cnt", 32'(bit_cnt), e.bc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    k = v;
    j = ~v;
    tick();
    k = 1'b0;
    j = 1'b0;
  endtask

  task automatic sync_now();
    synced_d = 1'b1;
    tick();
    synced_d = 1'b0;
  endtask

  task automatic retry_run(input int exp_total);
    do_start();
    for (int h = 0; h < T; h++) begin
      sync_err_d = (h == 2 || h == 5 || h == 7);
      if (h == 7) push_done(cyc + 1, 2, 0);
      tick();
    end
    sync_err_d = 1'b0;
    tick();
    chk("retry_err_total", 32'(sync_err_total), exp_total);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    {start, abort, k, j, se0, synced_d, sync_err_d} = '0;
    tick();
    tick();
    chk("rst_rx_en", 32'(rx_en), 0);
    chk("rst_det_rst", 32'(det_rst), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_bit_cnt", 32'(bit_cnt), 0);
    chk("rst_err_total", 32'(sync_err_total), 0);
    rst = 1'b0;
    tick();

    // Nominal: sync 3 cycles after start, 16 bits, EOP.
    do_start();
    chk("hunt_rx_en", 32'(rx_en), 1);
    chk("hunt_det_rst", 32'(det_rst), 0);
    tick();
    tick();
    sync_now();
    chk("recv_busy", 32'(busy), 1);
    chk("recv_rx_en", 32'(rx_en), 0);
    for (int i = 0; i < 16; i++) send_bit(i[0]);
    se0 = 1'b1;
    tick();
    push_done(cyc + 1, 0, 16);
    tick();
    se0 = 1'b0;
    start = 1'b1;
    tick();
    chk("done_start_ignored", 32'(busy), 0);
    chk("held_bit_cnt", 32'(bit_cnt), 16);
    tick();
    start = 1'b0;
    chk("restart_rx_en", 32'(rx_en), 1);
    chk("start_clears_bits", 32'(bit_cnt), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("hunt_abort_busy", 32'(busy), 0);
    tick();

    // Timeout: window is exactly T cycles.
    do_start();
    push_done(cyc + T, 1, 0);
    cnt = 0;
    for (int i = 0; i < T + 2; i++) begin
      if (rx_en) cnt++;
      tick();
    end
    chk("timeout_rx_en_cycles", cnt, T);

    // Retries, twice; third error lands on the final window cycle.
    retry_run(ERRCNT ? 3 : 0);
    retry_run(ERRCNT ? 6 : 0);

    // Babble with one isolated SE0 mid-stream.
    do_start();
    sync_now();
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    se0 = 1'b1;
    tick();
    se0 = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    chk("babble_busy_at_max", 32'(busy), 1);
    push_done(cyc + 1, 3, 16);
    send_bit(1'b1);
    tick();
    chk("babble_held_status", 32'(status), 3);
    chk("babble_held_bits", 32'(bit_cnt), 16);

    // Abort in RECV after 5 bits, abort coincident with a bit.
    do_start();
    sync_now();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    abort = 1'b1;
    k = 1'b1;
    tick();
    abort = 1'b0;
    k = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_det_rst", 32'(det_rst), 1);
    chk("abort_bit_cnt", 32'(bit_cnt), 5);
    chk("abort_status", 32'(status), 0);
    tick();
    tick();

    // Priority: sync and error together on the final window cycle.
    do_start();
    for (int h = 0; h < T - 1; h++) tick();
    synced_d = 1'b1;
    sync_err_d = 1'b1;
    tick();
    synced_d = 1'b0;
    sync_err_d = 1'b0;
    chk("prio_busy", 32'(busy), 1);
    chk("prio_in_recv", 32'(rx_en), 0);
    chk("prio_err_total", 32'(sync_err_total), ERRCNT ? 6 : 0);
    se0 = 1'b1;
    tick();
    push_done(cyc + 1, 0, 0);
    tick();
    se0 = 1'b0;
    tick();

    // Asynchronous reset mid-RECV.
    do_start();
    sync_now();
    for (int i = 0; i < 3; i++) send_bit(i[0]);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_det_rst", 32'(det_rst), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_bit_cnt", 32'(bit_cnt), 0);
    chk("arst_err_total", 32'(sync_err_total), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    chk("pending_done", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
